// File: rtl/vecmul_scheduler.sv
// Sweep sequencer for a shared vecmul datapath: issues weight rows,
// tracks in-flight products and returns row-tagged results via a FIFO.
module vecmul_scheduler #(
    parameter int PRECISION_BITS = 32,
    parameter int OVERFLOW_BITS  = 8,
    parameter int NUM_NODES      = 4,
    parameter int NUM_ROWS       = 4,
    parameter int VM_LATENCY     = 4,
    parameter int FIFO_DEPTH     = 8,
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int PW    = PRECISION_BITS + OVERFLOW_BITS,
    localparam int WW    = PRECISION_BITS * NUM_NODES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] node_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 w_rd_en,
    output logic [ROW_W-1:0]     w_addr,
    input  logic [WW-1:0]        w_rdata,
    output logic [NUM_NODES-1:0] vm_nodes,
    output logic [WW-1:0]        vm_weights,
    input  logic [PW-1:0]        vm_product,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [PW-1:0]        res_data,
    output logic [ROW_W-1:0]     res_row
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = AW + 1;
    localparam int NR_W = ROW_W + 1;
    localparam logic [NR_W-1:0] LAST_ROW = NR_W'(NUM_ROWS - 1);
    localparam logic [CW:0]     DEPTH_C  = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [NR_W-1:0]     next_row;
    logic [VM_LATENCY:0] pv;
    logic [ROW_W-1:0]    prow [VM_LATENCY+1];
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       count;
    logic [CW-1:0]       inflight_nxt;
    logic [CW-1:0]       count_nxt;
    logic [PW-1:0]       fdata [FIFO_DEPTH];
    logic [ROW_W-1:0]    frow  [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                credit_ok;
    logic                issue;
    logic                push;
    logic                pop;

    // Credits cover both queued results and products still in vecmul,
    // so a product can never arrive to a full FIFO.
    assign credit_ok = ({1'b0, inflight} + {1'b0, count}) < DEPTH_C;
    assign issue     = (state == RUN) && (next_row <= LAST_ROW) && credit_ok;
    assign push      = pv[VM_LATENCY];
    assign res_valid = (count != '0);
    assign pop       = res_valid && res_ready;

    assign w_rd_en    = issue;
    assign w_addr     = next_row[ROW_W-1:0];
    assign vm_weights = w_rdata;
    assign res_data   = res_valid ? fdata[rd_ptr] : '0;
    assign res_row    = res_valid ? frow[rd_ptr] : '0;

    always_comb begin
        inflight_nxt = inflight;
        count_nxt    = count;
        if (issue && !push)
            inflight_nxt = inflight + CW'(1);
        else if (!issue && push)
            inflight_nxt = inflight - CW'(1);
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (!push && pop)
            count_nxt = count - CW'(1);
    end

    // Valid pipe never stalls: vecmul has no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv       <= '0;
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            pv       <= {pv[VM_LATENCY-1:0], issue};
            inflight <= inflight_nxt;
            count    <= count_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        prow[0] <= w_addr;
        for (int i = 1; i <= VM_LATENCY; i++)
            prow[i] <= prow[i-1];
        if (push) begin
            fdata[wr_ptr] <= vm_product;
            frow[wr_ptr]  <= prow[VM_LATENCY];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            next_row <= '0;
            vm_nodes <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vm_nodes <= node_vec;
                        next_row <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        next_row <= next_row + NR_W'(1);
                        if (next_row == LAST_ROW)
                            state <= DRAIN;
                    end
                end
                // Look ahead so done lands the cycle after the last pop.
                DRAIN: begin
                    if (inflight_nxt == '0 && count_nxt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
